// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master: FSM states, response flags and watchdog sizing.
// No logic; imported by the top and the watchdog.
package apb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Status half of the response; the top wraps it with rdata of its own DATA_W.
    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_flags_t;

    // A disabled watchdog still gets a 1-bit counter so declarations stay legal.
    function automatic int wdog_cnt_w(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_WDOG_CNT_W     = wdog_cnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/apb_cmd_master_wdog.sv
// ACCESS wait-state counter: cleared on command accept, counts PREADY-low cycles.
// o_expire is high in the TIMEOUT_CYCLES-th consecutive wait cycle; tied low when TIMEOUT_CYCLES=0.
module apb_cmd_master_wdog
    import apb_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CNT_W = wdog_cnt_w(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_inc) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Expiry only fires on a wait cycle, so a PREADY in the limit cycle wins.
            assign o_expire = i_inc && (r_cnt == LAST);
        end else begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, HCLK, HRESETn, i_clr, i_inc};
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 requester: one valid/ready command becomes one APB transfer and one held response.
// Response valid 2 cycles after the command handshake with no wait states; one transfer outstanding, cmd_ready_o low until the response is consumed.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic              cmd_write_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        rsp_flags_t        flags;
    } rsp_t;

    state_e            r_state;
    state_e            w_state_nxt;
    rsp_t              r_rsp;
    rsp_t              w_rsp_nxt;
    logic              r_cmd_rdy;
    logic              r_psel;
    logic              r_penable;
    logic              r_rsp_vld;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_pwrite;
    logic              w_accept;
    logic              w_wait;
    logic              w_expire;

    // r_cmd_rdy mirrors IDLE one edge late so ready stays 0 while reset is held.
    assign w_accept = cmd_valid_i && r_cmd_rdy;
    assign w_wait   = (r_state == ST_ACCESS) && !PREADY;

    apb_cmd_master_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_clr   (w_accept),
        .i_inc   (w_wait),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_nxt   = r_rsp;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt           = ST_RESP;
                    w_rsp_nxt.rdata       = r_pwrite ? '0 : PRDATA;
                    w_rsp_nxt.flags.err   = PSLVERR;
                    w_rsp_nxt.flags.timeout = 1'b0;
                end else if (w_expire) begin
                    w_state_nxt           = ST_RESP;
                    w_rsp_nxt.rdata       = '0;
                    w_rsp_nxt.flags.err   = 1'b1;
                    w_rsp_nxt.flags.timeout = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= ST_IDLE;
            r_cmd_rdy <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp     <= '0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd_rdy <= (w_state_nxt == ST_IDLE);
            r_psel    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
            r_penable <= (w_state_nxt == ST_ACCESS);
            r_rsp_vld <= (w_state_nxt == ST_RESP);
            r_rsp     <= w_rsp_nxt;
            if (w_accept) begin
                r_paddr  <= cmd_addr_i;
                r_pwdata <= cmd_wdata_i;
                r_pwrite <= cmd_write_i;
            end
        end
    end

    assign cmd_ready_o   = r_cmd_rdy;
    assign rsp_valid_o   = r_rsp_vld;
    assign rsp_rdata_o   = r_rsp.rdata;
    assign rsp_err_o     = r_rsp.flags.err;
    assign rsp_timeout_o = r_rsp.flags.timeout;
    assign PADDR         = r_paddr;
    assign PWDATA        = r_pwdata;
    assign PWRITE        = r_pwrite;
    assign PSEL          = r_psel;
    assign PENABLE       = r_penable;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and random transfers against a transaction-level expectation of the APB master.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_apb_cmd_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic          cmd_write_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    apb_cmd_master #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_write_i(cmd_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One command end to end, acting as the APB target; expectations come from the transfer rules.
    task automatic xfer(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic wr,
                        input int waits, input logic slverr, input logic [DW-1:0] prdata,
                        input int rsp_hold);
        logic          exp_to;
        int            acc_len;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            guard;
        exp_to    = (waits >= TO);
        acc_len   = exp_to ? TO : waits + 1;
        exp_rdata = (wr || exp_to) ? '0 : prdata;
        exp_err   = exp_to || slverr;

        guard = 0;
        while (!cmd_ready_o && guard < 20) begin
            step();
            guard++;
        end
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'(1));

        cmd_valid_i = 1'b1;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_write_i = wr;
        step();
        cmd_valid_i = 1'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = $urandom;
        cmd_write_i = 1'($urandom);
        chk("setup_psel", 32'(PSEL), 32'(1));
        chk("setup_penable", 32'(PENABLE), 32'(0));
        chk("setup_paddr", 32'(PADDR), 32'(addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_cmd_ready", 32'(cmd_ready_o), 32'(0));
        step();

        for (int k = 1; k <= acc_len; k++) begin
            chk("access_psel", 32'(PSEL), 32'(1));
            chk("access_penable", 32'(PENABLE), 32'(1));
            chk("access_paddr", 32'(PADDR), 32'(addr));
            chk("access_pwdata", PWDATA, wdata);
            chk("access_rsp_valid", 32'(rsp_valid_o), 32'(0));
            PREADY  = (k == waits + 1);
            PSLVERR = PREADY ? slverr : 1'($urandom);
            PRDATA  = PREADY ? prdata : $urandom;
            step();
        end
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;

        chk("resp_psel", 32'(PSEL), 32'(0));
        chk("resp_penable", 32'(PENABLE), 32'(0));
        chk("resp_valid", 32'(rsp_valid_o), 32'(1));
        chk("resp_rdata", rsp_rdata_o, exp_rdata);
        chk("resp_err", 32'(rsp_err_o), 32'(exp_err));
        chk("resp_timeout", 32'(rsp_timeout_o), 32'(exp_to));
        chk("resp_cmd_ready", 32'(cmd_ready_o), 32'(0));
        chk("resp_paddr_kept", 32'(PADDR), 32'(addr));

        for (int d = 0; d < rsp_hold; d++) begin
            cmd_valid_i = 1'b1;
            step();
            chk("hold_valid", 32'(rsp_valid_o), 32'(1));
            chk("hold_rdata", rsp_rdata_o, exp_rdata);
            chk("hold_err", 32'(rsp_err_o), 32'(exp_err));
            chk("hold_timeout", 32'(rsp_timeout_o), 32'(exp_to));
            chk("hold_cmd_ready", 32'(cmd_ready_o), 32'(0));
            chk("hold_psel", 32'(PSEL), 32'(0));
        end

        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("done_cmd_ready", 32'(cmd_ready_o), 32'(1));
        chk("done_psel", 32'(PSEL), 32'(0));
    endtask

    initial begin
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata_o, 32'(0));
        chk("rst_rsp_err", 32'({rsp_err_o, rsp_timeout_o}), 32'(0));
        chk("rst_psel_penable", 32'({PSEL, PENABLE}), 32'(0));
        chk("rst_paddr", 32'(PADDR), 32'(0));
        chk("rst_pwdata", PWDATA, 32'(0));
        chk("rst_pwrite", 32'(PWRITE), 32'(0));

        step();
        HRESETn = 1'b1;
        step();
        step();

        xfer(12'h004, 32'hDEAD_BEEF, 1'b1, 0, 1'b0, 32'hA5A5_A5A5, 0);
        xfer(12'h010, 32'h0, 1'b0, 3, 1'b0, 32'h1234_5678, 1);
        xfer(12'h020, 32'h0, 1'b0, 1, 1'b1, 32'hCAFE_F00D, 0);
        xfer(12'h030, 32'h1111_2222, 1'b0, 40, 1'b0, 32'h5555_AAAA, 0);
        xfer(12'h034, 32'h0, 1'b0, TO - 1, 1'b0, 32'h0BAD_F00D, 0);
        xfer(12'h038, 32'h7777_8888, 1'b1, TO, 1'b0, 32'h0, 0);
        xfer(12'h03C, 32'h0, 1'b0, 2, 1'b0, 32'h8765_4321, 0);
        xfer(12'h040, 32'h0, 1'b0, 0, 1'b0, 32'hFEED_0001, 10);

        // Reset in the middle of ACCESS.
        cmd_valid_i = 1'b1;
        cmd_addr_i  = 12'h0AC;
        cmd_wdata_i = 32'h0;
        cmd_write_i = 1'b0;
        step();
        cmd_valid_i = 1'b0;
        step();
        step();
        chk("pre_rst_penable", 32'(PENABLE), 32'(1));
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst_psel", 32'(PSEL), 32'(0));
        chk("async_rst_penable", 32'(PENABLE), 32'(0));
        chk("async_rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        step();
        HRESETn = 1'b1;
        PREADY  = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'(1));
        chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        step();
        PREADY = 1'b0;
        chk("post_rst_no_stale_rsp", 32'(rsp_valid_o), 32'(0));
        chk("post_rst_psel", 32'(PSEL), 32'(0));

        for (int t = 0; t < 25; t++) begin
            xfer(AW'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 10)),
                 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
